// File: rtl/interval_timer.sv
// ---------------------------------------------------------------------------
// interval_timer
//
// Purpose:
//   Parametrised interval timer for the BlackJack game controller. It counts
//   enabled clk_2K cycles from zero up to a terminal count that is captured
//   when the timer is started. One-shot mode stops in EXPIRED after the first
//   terminal crossing. Periodic mode wraps back to zero and keeps running.
//   A saturating counter records how many ticks have occurred since start.
//
// Ports:
//   clk_2K       in   1         single 2 kHz system clock
//   i_Reset      in   1         synchronous active-high reset
//   i_Clear      in   1         synchronous clear of all state, back to IDLE
//   i_Start      in   1         capture terminal/mode, zero count, enter RUN
//   i_Enable     in   1         count advances only while high
//   i_Periodic   in   1         mode captured at start (1 periodic, 0 one-shot)
//   i_Terminal   in   WIDTH     terminal count captured at start, 0 = default
//   o_Count      out  WIDTH     current count
//   o_Tick       out  1         one-cycle pulse on each terminal crossing
//   o_Expired    out  1         high while in EXPIRED
//   o_Running    out  1         high while in RUN
//   o_Periods    out  PERIOD_W  ticks since start, saturating
// ---------------------------------------------------------------------------
module interval_timer #(
    parameter int WIDTH      = 12,
    parameter int DEFAULT_TC = 4095,
    parameter int PERIOD_W   = 4
) (
    input  logic                clk_2K,
    input  logic                i_Reset,
    input  logic                i_Clear,
    input  logic                i_Start,
    input  logic                i_Enable,
    input  logic                i_Periodic,
    input  logic [WIDTH-1:0]    i_Terminal,
    output logic [WIDTH-1:0]    o_Count,
    output logic                o_Tick,
    output logic                o_Expired,
    output logic                o_Running,
    output logic [PERIOD_W-1:0] o_Periods
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_RUN     = 2'd1;
    localparam logic [1:0] S_EXPIRED = 2'd2;

    localparam logic [WIDTH-1:0]    TC_DEFAULT  = WIDTH'(DEFAULT_TC);
    localparam logic [WIDTH-1:0]    COUNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] PERIODS_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
    localparam logic [PERIOD_W-1:0] PERIODS_MAX = {PERIOD_W{1'b1}};

    logic [1:0]          r_State;
    logic [WIDTH-1:0]    r_Count;
    logic [WIDTH-1:0]    r_Tc;
    logic                r_Mode;
    logic [PERIOD_W-1:0] r_Periods;
    logic                r_Tick;
    logic                r_Expired;
    logic                r_Running;

    logic [WIDTH-1:0]    w_StartTc;
    logic                w_AtTerminal;
    logic                w_Advance;

    // A terminal of zero would make the timer tick every cycle, so zero is
    // reserved to mean "use the default period" instead.
    assign w_StartTc    = (i_Terminal == '0) ? TC_DEFAULT : i_Terminal;
    assign w_AtTerminal = (r_Count == r_Tc);
    assign w_Advance    = (r_State == S_RUN) && i_Enable;

    // Main timer register block. Reset and clear share one branch since
    // they have identical effect; start outranks counting so a restart on a
    // terminal crossing discards that crossing without a tick. The count
    // only ever increments while below tc, so it can never pass tc or wrap,
    // even when tc is the all-ones value.
    always_ff @(posedge clk_2K) begin
        if (i_Reset || i_Clear) begin
            r_State   <= S_IDLE;
            r_Count   <= '0;
            r_Tc      <= '0;
            r_Mode    <= 1'b0;
            r_Periods <= '0;
            r_Tick    <= 1'b0;
            r_Expired <= 1'b0;
            r_Running <= 1'b0;
        end else if (i_Start) begin
            r_State   <= S_RUN;
            r_Count   <= '0;
            r_Tc      <= w_StartTc;
            r_Mode    <= i_Periodic;
            r_Periods <= '0;
            r_Tick    <= 1'b0;
            r_Expired <= 1'b0;
            r_Running <= 1'b1;
        end else begin
            r_Tick <= 1'b0;
            if (w_Advance) begin
                if (w_AtTerminal) begin
                    r_Tick <= 1'b1;
                    if (r_Periods != PERIODS_MAX) begin
                        r_Periods <= r_Periods + PERIODS_ONE;
                    end
                    if (r_Mode) begin
                        r_Count <= '0;
                    end else begin
                        // One-shot: count stays parked at tc while expired.
                        r_State   <= S_EXPIRED;
                        r_Expired <= 1'b1;
                        r_Running <= 1'b0;
                    end
                end else begin
                    r_Count <= r_Count + COUNT_ONE;
                end
            end
        end
    end

    assign o_Count   = r_Count;
    assign o_Tick    = r_Tick;
    assign o_Expired = r_Expired;
    assign o_Running = r_Running;
    assign o_Periods = r_Periods;

endmodule

// File: tb/tb_interval_timer.sv
// ---------------------------------------------------------------------------
// tb_interval_timer
//
// Purpose:
//   Self-checking bench for interval_timer. A behavioural model tracks the
//   number of enabled cycles since start and derives the expected outputs
//   from that with plain arithmetic (modulo for periodic, clamp for one-shot).
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_interval_timer;

    localparam int WIDTH      = 12;
    localparam int DEFAULT_TC = 4095;
    localparam int PERIOD_W   = 4;
    localparam int PMAX       = 15;
    localparam int VW         = WIDTH + PERIOD_W + 3;

    logic                clk_2K = 1'b0;
    logic                i_Reset;
    logic                i_Clear;
    logic                i_Start;
    logic                i_Enable;
    logic                i_Periodic;
    logic [WIDTH-1:0]    i_Terminal;
    logic [WIDTH-1:0]    o_Count;
    logic                o_Tick;
    logic                o_Expired;
    logic                o_Running;
    logic [PERIOD_W-1:0] o_Periods;

    logic [VW-1:0]       dutVec;

    int nChecks = 0;
    int nBad    = 0;

    // Behavioural model state: enabled cycles counted since the last start.
    bit mStarted  = 1'b0;
    bit mPeriodic = 1'b0;
    int mTc       = 0;
    int mCycles   = 0;
    bit mTick     = 1'b0;

    interval_timer #(
        .WIDTH      (WIDTH),
        .DEFAULT_TC (DEFAULT_TC),
        .PERIOD_W   (PERIOD_W)
    ) dut (
        .clk_2K     (clk_2K),
        .i_Reset    (i_Reset),
        .i_Clear    (i_Clear),
        .i_Start    (i_Start),
        .i_Enable   (i_Enable),
        .i_Periodic (i_Periodic),
        .i_Terminal (i_Terminal),
        .o_Count    (o_Count),
        .o_Tick     (o_Tick),
        .o_Expired  (o_Expired),
        .o_Running  (o_Running),
        .o_Periods  (o_Periods)
    );

    assign dutVec = {o_Count, o_Tick, o_Expired, o_Running, o_Periods};

    always #5 clk_2K = ~clk_2K;

    // Watchdog so a stuck run still ends.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Model is running while started, unless a one-shot has used up its
    // single period of tc+1 enabled cycles.
    function automatic bit modelRunning();
        return mStarted && (mPeriodic || (mCycles < mTc + 1));
    endfunction

    // Expected packed output vector derived from the enabled-cycle total.
    function automatic logic [VW-1:0] expVec();
        int cnt;
        int per;
        bit run;
        bit expd;
        run  = modelRunning();
        expd = mStarted && !run;
        if (!mStarted)      cnt = 0;
        else if (mPeriodic) cnt = mCycles % (mTc + 1);
        else                cnt = (mCycles < mTc) ? mCycles : mTc;
        per = mStarted ? mCycles / (mTc + 1) : 0;
        if (per > PMAX) per = PMAX;
        return {cnt[WIDTH-1:0], mTick, expd, run, per[PERIOD_W-1:0]};
    endfunction

    // Advance the model with the inputs the DUT is about to sample, then
    // move to 1 time unit after the clock edge for sampling.
    task automatic applyStimulus();
        if (i_Reset || i_Clear) begin
            mStarted  = 1'b0;
            mPeriodic = 1'b0;
            mTc       = 0;
            mCycles   = 0;
            mTick     = 1'b0;
        end else if (i_Start) begin
            mStarted  = 1'b1;
            mPeriodic = i_Periodic;
            mTc       = (i_Terminal == 0) ? DEFAULT_TC : int'(i_Terminal);
            mCycles   = 0;
            mTick     = 1'b0;
        end else begin
            mTick = 1'b0;
            if (modelRunning() && i_Enable) begin
                mCycles = mCycles + 1;
                mTick   = ((mCycles % (mTc + 1)) == 0);
            end
        end
        @(posedge clk_2K);
        #1;
    endtask

    task automatic startTimer(input int term, input bit periodic);
        i_Terminal = WIDTH'(term);
        i_Periodic = periodic;
        i_Start    = 1'b1;
        applyStimulus();
        i_Start    = 1'b0;
        i_Terminal = WIDTH'($urandom);
        i_Periodic = 1'($urandom);
    endtask

    // Reset for three cycles, then enable with no start: everything stays 0.
    task automatic test_reset();
        i_Reset = 1'b1;
        repeat (3) applyStimulus();
        i_Reset = 1'b0;
        nChecks++;
        if (dutVec !== '0) begin
            nBad++;
            $display("[TB] FAIL reset_state: got %h required %h", dutVec, {VW{1'b0}});
        end
        i_Enable = 1'b1;
        for (int n = 0; n < 50; n++) begin
            applyStimulus();
            nChecks++;
            if (dutVec !== '0) begin
                nBad++;
                $display("[TB] FAIL idle_hold: got %h required %h", dutVec, {VW{1'b0}});
            end
        end
    endtask

    // Default one-shot: tick 4096 cycles after start, then parked at 4095.
    task automatic test_default_oneshot();
        int tickAt;
        i_Enable = 1'b1;
        startTimer(0, 1'b0);
        nChecks++;
        if ({o_Count, o_Running} !== {12'd0, 1'b1}) begin
            nBad++;
            $display("[TB] FAIL oneshot_start: got %h required %h", {o_Count, o_Running}, {12'd0, 1'b1});
        end
        tickAt = -1;
        for (int n = 1; n <= 5000 && tickAt < 0; n++) begin
            applyStimulus();
            nChecks++;
            if (dutVec !== expVec()) begin
                nBad++;
                $display("[TB] FAIL oneshot_track: got %h required %h", dutVec, expVec());
            end
            if (o_Tick === 1'b1) tickAt = n;
        end
        nChecks++;
        if (tickAt !== 4096) begin
            nBad++;
            $display("[TB] FAIL oneshot_tick_time: got %0d required %0d", tickAt, 4096);
        end
        for (int n = 0; n < 100; n++) begin
            i_Enable = 1'($urandom);
            applyStimulus();
            nChecks++;
            if (dutVec !== {12'd4095, 1'b0, 1'b1, 1'b0, 4'd1}) begin
                nBad++;
                $display("[TB] FAIL oneshot_expired_hold: got %h required %h", dutVec, {12'd4095, 1'b0, 1'b1, 1'b0, 4'd1});
            end
        end
    endtask

    // Periodic tc=9 with a 7-cycle pause: first tick at 17, then every 10.
    task automatic test_periodic_pause();
        int ticks[$];
        i_Enable = 1'b1;
        startTimer(9, 1'b1);
        for (int n = 1; n <= 200; n++) begin
            i_Enable = (n >= 4 && n <= 10) ? 1'b0 : 1'b1;
            applyStimulus();
            nChecks++;
            if (dutVec !== expVec()) begin
                nBad++;
                $display("[TB] FAIL periodic_track: got %h required %h", dutVec, expVec());
            end
            if (o_Tick === 1'b1) ticks.push_back(n);
        end
        nChecks++;
        if (ticks.size() !== 19) begin
            nBad++;
            $display("[TB] FAIL periodic_tick_count: got %0d required %0d", ticks.size(), 19);
        end
        for (int j = 0; j < ticks.size(); j++) begin
            nChecks++;
            if (ticks[j] !== 17 + 10 * j) begin
                nBad++;
                $display("[TB] FAIL periodic_tick_time: got %0d required %0d", ticks[j], 17 + 10 * j);
            end
        end
        nChecks++;
        if (o_Periods !== 4'd15) begin
            nBad++;
            $display("[TB] FAIL periodic_saturate: got %0d required %0d", o_Periods, 15);
        end
    endtask

    // Restart at count 12 of tc=20: back to 0, no tick, next tick 21 later.
    task automatic test_restart();
        bit reached;
        int tickAt;
        i_Enable = 1'b1;
        startTimer(20, 1'b0);
        reached = 1'b0;
        for (int n = 0; n < 40 && !reached; n++) begin
            applyStimulus();
            if (o_Count === 12'd12) reached = 1'b1;
        end
        nChecks++;
        if (!reached) begin
            nBad++;
            $display("[TB] FAIL restart_reach12: got %0d required %0d", o_Count, 12);
        end
        startTimer(20, 1'b0);
        nChecks++;
        if ({o_Count, o_Tick, o_Running} !== {12'd0, 1'b0, 1'b1}) begin
            nBad++;
            $display("[TB] FAIL restart_state: got %h required %h", {o_Count, o_Tick, o_Running}, {12'd0, 1'b0, 1'b1});
        end
        tickAt = -1;
        for (int n = 1; n <= 40 && tickAt < 0; n++) begin
            applyStimulus();
            nChecks++;
            if (dutVec !== expVec()) begin
                nBad++;
                $display("[TB] FAIL restart_track: got %h required %h", dutVec, expVec());
            end
            if (o_Tick === 1'b1) tickAt = n;
        end
        nChecks++;
        if (tickAt !== 21) begin
            nBad++;
            $display("[TB] FAIL restart_tick_time: got %0d required %0d", tickAt, 21);
        end
    endtask

    // Clear together with start: clear wins, timer is idle.
    task automatic test_clear_start();
        i_Enable = 1'b1;
        startTimer(30, 1'b1);
        repeat (5) applyStimulus();
        i_Clear    = 1'b1;
        i_Start    = 1'b1;
        i_Terminal = 12'd7;
        applyStimulus();
        i_Clear = 1'b0;
        i_Start = 1'b0;
        nChecks++;
        if (dutVec !== '0) begin
            nBad++;
            $display("[TB] FAIL clear_start: got %h required %h", dutVec, {VW{1'b0}});
        end
    endtask

    // Start coincident with a terminal crossing: no tick, periods stay 0.
    task automatic test_start_at_tick();
        i_Enable = 1'b1;
        startTimer(6, 1'b1);
        repeat (6) applyStimulus();
        nChecks++;
        if (o_Count !== 12'd6) begin
            nBad++;
            $display("[TB] FAIL start_tick_pre: got %0d required %0d", o_Count, 6);
        end
        startTimer(6, 1'b1);
        nChecks++;
        if (dutVec !== {12'd0, 1'b0, 1'b0, 1'b1, 4'd0}) begin
            nBad++;
            $display("[TB] FAIL start_at_tick: got %h required %h", dutVec, {12'd0, 1'b0, 1'b0, 1'b1, 4'd0});
        end
    endtask

    // Reset on the edge where the tick is due: tick suppressed, all zero.
    task automatic test_reset_at_tick();
        i_Enable = 1'b1;
        startTimer(5, 1'b1);
        repeat (5) applyStimulus();
        nChecks++;
        if (o_Count !== 12'd5) begin
            nBad++;
            $display("[TB] FAIL reset_tick_pre: got %0d required %0d", o_Count, 5);
        end
        i_Reset = 1'b1;
        applyStimulus();
        i_Reset = 1'b0;
        nChecks++;
        if (dutVec !== '0) begin
            nBad++;
            $display("[TB] FAIL reset_at_tick: got %h required %h", dutVec, {VW{1'b0}});
        end
        applyStimulus();
        nChecks++;
        if (dutVec !== '0) begin
            nBad++;
            $display("[TB] FAIL reset_after_tick: got %h required %h", dutVec, {VW{1'b0}});
        end
    endtask

    // Random tc, mode and enable pattern compared to the model every cycle.
    task automatic test_random();
        int tc;
        for (int r = 0; r < 4; r++) begin
            tc = (r < 2) ? int'($urandom_range(1, 40)) : int'($urandom_range(1, 4095));
            i_Enable = 1'b1;
            startTimer(tc, 1'($urandom));
            for (int n = 0; n < 1500; n++) begin
                i_Enable   = ($urandom_range(0, 3) != 0);
                i_Terminal = WIDTH'($urandom);
                applyStimulus();
                nChecks++;
                if (dutVec !== expVec()) begin
                    nBad++;
                    $display("[TB] FAIL random_track: got %h required %h (tc=%0d)", dutVec, expVec(), tc);
                end
            end
        end
    endtask

    initial begin
        i_Reset    = 1'b0;
        i_Clear    = 1'b0;
        i_Start    = 1'b0;
        i_Enable   = 1'b0;
        i_Periodic = 1'b0;
        i_Terminal = '0;
        test_reset();
        test_default_oneshot();
        test_periodic_pause();
        test_restart();
        test_clear_start();
        test_start_at_tick();
        test_reset_at_tick();
        test_random();
        $display("test done: total=%0d bad=%0d", nChecks, nBad);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
# interval_timer

Parametrised interval timer that replaces the fixed two-second counter in the BlackJack game controller. It counts enabled `clk_2K` cycles up to a terminal count loaded at start time and signals expiry. It supports one-shot and periodic modes, pause via an enable input, and a saturating period counter. The game FSM uses it for dealer delays, display blink periods and player-response timeouts.

## Interface
Parameters:
- `WIDTH`, 12: width of count and terminal value.
- `DEFAULT_TC`, 4095: terminal count used when `i_Terminal` is 0 at start. 4096 cycles at 2 kHz ≈ 2 s.
- `PERIOD_W`, 4: width of the saturating period counter.

Ports:
- `clk_2K`  in  1  the single clock, 2 kHz system clock.
- `i_Reset`  in  1  synchronous, active-high reset.
- `i_Clear`  in  1  synchronous: zero all state, go to IDLE.
- `i_Start`  in  1  load terminal and mode, zero the count, go to RUN.
- `i_Enable`  in  1  count advances only while high; low pauses.
- `i_Periodic`  in  1  mode, sampled at start: 1 = periodic, 0 = one-shot.
- `i_Terminal`  in  WIDTH  terminal count, sampled at start; 0 selects `DEFAULT_TC`.
- `o_Count`  out  WIDTH  current count.
- `o_Tick`  out  1  one-cycle pulse on each terminal crossing.
- `o_Expired`  out  1  high while in EXPIRED (one-shot only).
- `o_Running`  out  1  high while in RUN.
- `o_Periods`  out  PERIOD_W  number of ticks since start, saturating.

## Operation
- States: IDLE, RUN, EXPIRED.
- All outputs are registered.
- Priority, highest first: `i_Reset`, `i_Clear`, `i_Start`, counting.
- `i_Reset` or `i_Clear`:
  - state IDLE.
  - count, tc register, mode register, `o_Periods` all 0.
  - `o_Tick`, `o_Expired`, `o_Running` all 0.
- `i_Start`, from any state including RUN and EXPIRED:
  - tc ← `i_Terminal`, or `DEFAULT_TC` if `i_Terminal` is 0.
  - mode ← `i_Periodic`.
  - count ← 0, `o_Periods` ← 0, state RUN.
  - Restarting while in RUN discards the in-progress period, with no tick.
- RUN with `i_Enable`=0: all state holds; `o_Tick`=0.
- RUN with `i_Enable`=1 and count < tc: count+1.
- RUN with `i_Enable`=1 and count == tc:
  - `o_Tick`=1 next cycle.
  - `o_Periods` increments, saturating at 2^PERIOD_W−1.
  - Periodic mode: count ← 0, stay in RUN.
  - One-shot mode: count holds at tc, state EXPIRED.
- EXPIRED:
  - count holds at tc; `i_Enable` is ignored.
  - Exits only on start, clear or reset.
- IDLE: count holds at 0; `i_Enable` is ignored.
- Arithmetic:
  - Count never exceeds tc and never wraps past 2^WIDTH−1.
  - tc = 2^WIDTH−1 is legal.
  - Count is unsigned.
- `i_Terminal` and `i_Periodic` are don't-care except in the start cycle.

## Timing
- Reset values: `o_Count`=0, `o_Tick`=0, `o_Expired`=0, `o_Running`=0, `o_Periods`=0.
- Start at edge k:
  - `o_Count`=0 and `o_Running`=1 from edge k.
  - With `i_Enable` held high, `o_Count`=tc after edge k+tc.
  - `o_Tick`=1 after edge k+tc+1.
- Period = tc+1 enabled cycles. With default tc and continuous enable, the tick comes 4096 cycles after start.
- One-shot:
  - `o_Expired`=1 and `o_Running`=0 from the same edge that raises `o_Tick`.
  - `o_Tick` drops after one cycle; `o_Expired` stays high.
- Periodic: ticks are spaced exactly tc+1 enabled cycles apart. Paused cycles stretch the spacing one-for-one.
- `i_Start` coincident with a terminal crossing: start wins; no tick; `o_Periods`=0.
- `i_Clear` coincident with `i_Start`: clear wins; result is IDLE.
- `i_Reset` mid-period: all outputs return to reset values at that edge. Any tick due on that edge is suppressed.
- `o_Tick` is never high for two consecutive cycles unless tc=0. tc=0 is unreachable via `i_Terminal` because 0 selects the default.

## Test plan
- Reset/idle: hold `i_Reset` 3 cycles, then `i_Enable`=1 for 50 cycles with no start → all outputs stay 0.
- Default one-shot: start with `i_Terminal`=0, `i_Periodic`=0, `i_Enable`=1:
  - `o_Tick` pulses exactly at start+4096 cycles.
  - `o_Expired`=1; `o_Count` holds 4095 for 100 more cycles.
  - `o_Periods`=1.
- Periodic with pause: start with `i_Terminal`=9, `i_Periodic`=1; drop `i_Enable` for 7 cycles mid-period:
  - First tick at start+17.
  - Subsequent ticks every 10 cycles.
  - `o_Periods` saturates at 15 after 15 ticks and stays there.
- Restart and priority:
  - Start with tc=20, then restart at count=12 → count 0, no tick; next tick 21 cycles later.
  - `i_Clear` and `i_Start` together → IDLE, `o_Count`=0.
- Mid-run reset:
  - Assert `i_Reset` on the edge where the tick is due → no tick; all outputs 0 next cycle.
- Random: for a random tc in 1..4095 and a random enable pattern → a reference model counting enabled cycles matches `o_Count` every cycle.
